imm_encode: RTL

//   Inverse of the immediate extender: packs a 32-bit immediate into the RISC-V

---
 rtl/imm_encode.sv | 99 +++++++++
 1 files changed

// File: rtl/imm_encode.sv
// imm_encode: packs a 32-bit immediate into RISC-V immediate fields via a 2-stage valid/ready pipeline
module imm_encode #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      InstrIn,
  input  logic [31:0]      ImmIn,
  input  logic [2:0]       ImmSrc,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [31:0]      InstrOut,
  output logic             OutErr,
  input  logic             ErrClr,
  output logic [CNT_W-1:0] ErrCount
);
  logic        s1_valid_q;
  logic [31:0] s1_instr_q;
  logic [31:0] s1_imm_q;
  logic [2:0]  s1_src_q;
  logic        s1_err_q;
  logic        s1_err_d;
  logic [31:0] pack_d;
  logic        s2_adv;
  // stage 2 can take a beat when empty or being drained this edge
  always_comb begin
    s2_adv  = !OutValid || OutReady;
    InReady = !s1_valid_q || s2_adv;
  end
  // representability of the incoming immediate in the selected format
  always_comb
    s1_err_d = (ImmSrc == 3'd0 || ImmSrc == 3'd1) ? !(&ImmIn[31:11] || ~|ImmIn[31:11]) :
               (ImmSrc == 3'd2) ? !(&ImmIn[31:12] || ~|ImmIn[31:12]) || ImmIn[0] :
               (ImmSrc == 3'd3) ? |ImmIn[11:0] :
               (ImmSrc == 3'd4) ? !(&ImmIn[31:20] || ~|ImmIn[31:20]) || ImmIn[0] :
               1'b1;
  // scatter the stage-1 immediate into the template; invalid formats pass through
  always_comb begin
    pack_d = s1_instr_q;
    case (s1_src_q)
      3'd0: pack_d[31:20] = s1_imm_q[11:0];
      3'd1: begin
        pack_d[31:25] = s1_imm_q[11:5];
        pack_d[11:7]  = s1_imm_q[4:0];
      end
      3'd2: begin
        pack_d[31]    = s1_imm_q[12];
        pack_d[30:25] = s1_imm_q[10:5];
        pack_d[11:8]  = s1_imm_q[4:1];
        pack_d[7]     = s1_imm_q[11];
      end
      3'd3: pack_d[31:12] = s1_imm_q[31:12];
      3'd4: begin
        pack_d[31]    = s1_imm_q[20];
        pack_d[30:21] = s1_imm_q[10:1];
        pack_d[20]    = s1_imm_q[11];
        pack_d[19:12] = s1_imm_q[19:12];
      end
      default: ;
    endcase
  end
  // stage 1: capture inputs and range-check result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_imm_q   <= '0;
      s1_src_q   <= '0;
      s1_err_q   <= 1'b0;
    end else if (InReady) begin
      s1_valid_q <= InValid;
      if (InValid) begin
        s1_instr_q <= InstrIn;
        s1_imm_q   <= ImmIn;
        s1_src_q   <= ImmSrc;
        s1_err_q   <= s1_err_d;
      end
    end
  // stage 2: registered packed instruction, held while stalled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      OutValid <= 1'b0;
      InstrOut <= '0;
      OutErr   <= 1'b0;
    end else if (s2_adv) begin
      OutValid <= s1_valid_q;
      if (s1_valid_q) begin
        InstrOut <= pack_d;
        OutErr   <= s1_err_q;
      end
    end
  // saturating count of errored beats delivered; clear has priority
  always_ff @(posedge clk or posedge rst)
    if (rst) ErrCount <= '0;
    else if (ErrClr) ErrCount <= '0;
    else if (OutValid && OutReady && OutErr && ErrCount != {CNT_W{1'b1}}) ErrCount <= ErrCount + 1'b1;
endmodule
